seg_scan_p2s: RTL

//  Frame sequencer for the serial 7-segment display path. Drives the digit-select
//  of the 8-bit 8:1 segment-byte mux, captures each selected byte and shifts it
//  MSB-first onto the board's serial segment chain (clock/data/latch).

---
 rtl/seg_scan_p2s_if.sv | 44 ++++
 rtl/seg_scan_p2s.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_p2s_if.sv
// Segment-scan bus between the frame sequencer and its environment.
//   start   : frame request into the sequencer
//   seg_in  : byte returned by the segment mux for the current sel
//   sel     : digit select to the segment mux
//   sclk    : serial shift clock to the external chain
//   sdat    : serial data, stable across each sclk rising edge
//   sle     : latch strobe to the external chain
//   busy    : frame in progress
//   done    : one-cycle end-of-frame pulse
// master: the sequencer side. slave: the mux / chain / requester side.
interface seg_scan_p2s_if #(
  parameter int unsigned SEG_W = 8
);
  logic             start;
  logic [SEG_W-1:0] seg_in;
  logic [2:0]       sel;
  logic             sclk;
  logic             sdat;
  logic             sle;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    input  seg_in,
    output sel,
    output sclk,
    output sdat,
    output sle,
    output busy,
    output done
  );

  modport slave (
    output start,
    output seg_in,
    input  sel,
    input  sclk,
    input  sdat,
    input  sle,
    input  busy,
    input  done
  );
endinterface

// File: rtl/seg_scan_p2s.sv
// Frame sequencer for the serial 7-segment display path. Steps the digit select of
// the segment-byte mux, captures each selected byte and shifts it MSB-first onto the
// serial segment chain, then pulses the chain latch.
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : seg_scan_p2s_if master (start/seg_in in; sel/sclk/sdat/sle/busy/done out)
// Parameters: DIGITS bytes per frame (2..8), SEG_W bits per byte,
// CLK_DIV clk cycles per sclk half-period (>=1).
module seg_scan_p2s #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned SEG_W   = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_p2s_if.master bus
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (SEG_W > 1) ? $clog2(SEG_W) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(SEG_W - 1);
  localparam logic [2:0]      DigLast = 3'(DIGITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StLatch,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [2:0]       digit_q, digit_d;
  logic [SEG_W-1:0] shreg_q, shreg_d;

  logic div_last, bit_last, digit_last;

  assign div_last   = (div_q == DivLast);
  assign bit_last   = (bit_q == BitLast);
  assign digit_last = (digit_q == DigLast);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.start) state_d = StLoad;
      StLoad:    state_d = StShiftLo;
      StShiftLo: if (div_last) state_d = StShiftHi;
      StShiftHi: begin
        if (div_last) begin
          if (!bit_last)       state_d = StShiftLo;
          else if (digit_last) state_d = StLatch;
          else                 state_d = StLoad;
        end
      end
      StLatch:   if (div_last) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath: phase divider, bit/digit counters and shift register
  always_comb begin
    div_d   = '0;
    bit_d   = bit_q;
    digit_d = digit_q;
    shreg_d = shreg_q;

    // Divider runs only in timed phases and restarts at every phase boundary.
    if ((state_q == StShiftLo || state_q == StShiftHi || state_q == StLatch) && !div_last) begin
      div_d = div_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) digit_d = '0;
      end
      StLoad: begin
        shreg_d = bus.seg_in;
        bit_d   = '0;
      end
      StShiftHi: begin
        if (div_last) begin
          // Shift only after the HI phase so sdat holds across the sclk rise.
          shreg_d = shreg_q << 1;
          bit_d   = bit_last ? '0 : bit_q + 1'b1;
          if (bit_last && !digit_last) digit_d = digit_q + 1'b1;
        end
      end
      StDone: begin
        digit_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bit_q   <= '0;
      digit_q <= '0;
      shreg_q <= '0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      digit_q <= digit_d;
      shreg_q <= shreg_d;
    end
  end

  // Output decode; everything derives from reset-cleared registers so an
  // asynchronous reset forces all outputs low immediately.
  always_comb begin
    bus.sel  = digit_q;
    bus.sclk = 1'b0;
    bus.sdat = 1'b0;
    bus.sle  = 1'b0;
    bus.busy = (state_q != StIdle);
    bus.done = 1'b0;
    unique case (state_q)
      StShiftLo: bus.sdat = shreg_q[SEG_W-1];
      StShiftHi: begin
        bus.sclk = 1'b1;
        bus.sdat = shreg_q[SEG_W-1];
      end
      StLatch:   bus.sle  = 1'b1;
      StDone:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
